lsu_ctrl: RTL and testbench

//  Load/store sequencer between the decode/control stage and the data-memory port.

---
 rtl/lsu_ctrl.sv | 173 +++++++++++++++++
 tb/tb_lsu_ctrl.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/lsu_ctrl.sv
// Load/store sequencer: one access per req_valid, done 3 cycles after accept at best (errors at 1).
// The dmem request is held until gnt; the core is held on stall until done, and req_valid drops are ignored mid-access.
module lsu_ctrl #(
   parameter int AW      = 32,
   parameter int DW      = 32,
   parameter int TIMEOUT = 64
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            req_valid,
   input  logic            is_load,
   input  logic            is_store,
   input  logic [2:0]      func3,
   input  logic [AW-1:0]   addr,
   input  logic [DW-1:0]   wdata,
   output logic            stall,
   output logic            done,
   output logic [1:0]      err_code,
   output logic [DW-1:0]   rdata_out,
   output logic            dmem_req,
   output logic            dmem_we,
   output logic [AW-1:0]   dmem_addr,
   output logic [DW/8-1:0] dmem_be,
   output logic [DW-1:0]   dmem_wdata,
   input  logic            dmem_gnt,
   input  logic            dmem_rvalid,
   input  logic [DW-1:0]   dmem_rdata
);

   localparam int BW = DW / 8;
   localparam int CW = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] TO_MAX = CW'(TIMEOUT - 1);

   typedef enum logic [2:0] {IDLE, REQ, RSP, DONE, ERR} state_t;

   state_t          state;
   logic [2:0]      op_f3;
   logic [1:0]      op_off;
   logic [CW-1:0]   tmo_cnt;

   logic            illegal;
   logic            misalign;
   logic [BW-1:0]   be_nxt;
   logic [DW-1:0]   wd_nxt;
   logic [DW-1:0]   sh;
   logic [DW-1:0]   ld_ext;

   assign stall = req_valid && !done;

   // Decode of the incoming op, evaluated only while IDLE.
   always_comb begin
      illegal  = 1'b0;
      misalign = 1'b0;
      be_nxt   = '1;
      wd_nxt   = wdata;
      if (is_load == is_store)
         illegal = 1'b1;
      else if (is_store)
         illegal = !(func3 inside {3'b000, 3'b001, 3'b010});
      else
         illegal = !(func3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
      misalign = ((func3[1:0] == 2'b01) && addr[0]) ||
                 ((func3[1:0] == 2'b10) && (addr[1:0] != 2'b00));
      case (func3[1:0])
         2'b00: begin
            be_nxt = BW'(1) << addr[1:0];
            wd_nxt = {BW{wdata[7:0]}};
         end
         2'b01: begin
            be_nxt = BW'(3) << addr[1:0];
            wd_nxt = {(BW/2){wdata[15:0]}};
         end
         default: begin
            be_nxt = '1;
            wd_nxt = wdata;
         end
      endcase
   end

   always_comb begin
      sh     = dmem_rdata >> {op_off, 3'b000};
      ld_ext = sh;
      case (op_f3)
         3'b000:  ld_ext = {{(DW-8){sh[7]}}, sh[7:0]};
         3'b001:  ld_ext = {{(DW-16){sh[15]}}, sh[15:0]};
         3'b100:  ld_ext = {{(DW-8){1'b0}}, sh[7:0]};
         3'b101:  ld_ext = {{(DW-16){1'b0}}, sh[15:0]};
         default: ld_ext = sh;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         done       <= 1'b0;
         err_code   <= 2'b00;
         rdata_out  <= '0;
         dmem_req   <= 1'b0;
         dmem_we    <= 1'b0;
         dmem_addr  <= '0;
         dmem_be    <= '0;
         dmem_wdata <= '0;
         op_f3      <= 3'b000;
         op_off     <= 2'b00;
         tmo_cnt    <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (req_valid) begin
                  if (illegal) begin
                     state     <= ERR;
                     done      <= 1'b1;
                     err_code  <= 2'b11;
                     rdata_out <= '0;
                  end else if (misalign) begin
                     state     <= ERR;
                     done      <= 1'b1;
                     err_code  <= 2'b01;
                     rdata_out <= '0;
                  end else begin
                     state      <= REQ;
                     dmem_req   <= 1'b1;
                     dmem_we    <= is_store;
                     dmem_addr  <= {addr[AW-1:2], 2'b00};
                     dmem_be    <= be_nxt;
                     dmem_wdata <= wd_nxt;
                     op_f3      <= func3;
                     op_off     <= addr[1:0];
                     tmo_cnt    <= '0;
                  end
               end
            end
            REQ: begin
               if (dmem_gnt) begin
                  state    <= RSP;
                  dmem_req <= 1'b0;
                  tmo_cnt  <= tmo_cnt + CW'(1);
               end else if (tmo_cnt == TO_MAX) begin
                  state     <= ERR;
                  dmem_req  <= 1'b0;
                  done      <= 1'b1;
                  err_code  <= 2'b10;
                  rdata_out <= '0;
               end else begin
                  tmo_cnt <= tmo_cnt + CW'(1);
               end
            end
            RSP: begin
               // rvalid doubles as the write ack, so stores finish here too.
               if (dmem_rvalid) begin
                  state     <= DONE;
                  done      <= 1'b1;
                  err_code  <= 2'b00;
                  rdata_out <= dmem_we ? '0 : ld_ext;
               end else if (tmo_cnt == TO_MAX) begin
                  state     <= ERR;
                  done      <= 1'b1;
                  err_code  <= 2'b10;
                  rdata_out <= '0;
               end else begin
                  tmo_cnt <= tmo_cnt + CW'(1);
               end
            end
            default: begin
               state    <= IDLE;
               err_code <= 2'b00;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed bench for lsu_ctrl: inputs driven and outputs sampled on the falling edge.
module tb_lsu_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_valid, is_load, is_store;
   logic [2:0]  func3;
   logic [31:0] addr, wdata;
   logic        stall, done;
   logic [1:0]  err_code;
   logic [31:0] rdata_out;
   logic        dmem_req, dmem_we;
   logic [31:0] dmem_addr;
   logic [3:0]  dmem_be;
   logic [31:0] dmem_wdata;
   logic        dmem_gnt, dmem_rvalid;
   logic [31:0] dmem_rdata;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   lsu_ctrl #(.AW(32), .DW(32), .TIMEOUT(64)) dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .is_load(is_load),
      .is_store(is_store), .func3(func3), .addr(addr), .wdata(wdata),
      .stall(stall), .done(done), .err_code(err_code), .rdata_out(rdata_out),
      .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
      .dmem_be(dmem_be), .dmem_wdata(dmem_wdata), .dmem_gnt(dmem_gnt),
      .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic access_ok(input logic ld, input logic st, input logic [2:0] f3,
                            input logic [31:0] a, input logic [31:0] wd,
                            input logic [31:0] rd, input logic [3:0] exp_be,
                            input logic [31:0] exp_wd, input logic [31:0] exp_rd,
                            input int gdly);
      @(negedge clk);
      req_valid = 1'b1; is_load = ld; is_store = st; func3 = f3; addr = a; wdata = wd;
      @(negedge clk);
      chk("req_c1", dmem_req, 1);
      chk("stall_c1", stall, 1);
      chk("addr", dmem_addr, {a[31:2], 2'b00});
      chk("be", dmem_be, exp_be);
      chk("we", dmem_we, st);
      if (st) chk("wdata", dmem_wdata, exp_wd);
      for (int i = 0; i < gdly; i++) begin
         dmem_rvalid = 1'b1;
         @(negedge clk);
         dmem_rvalid = 1'b0;
         chk("req_held", dmem_req, 1);
         chk("no_done_req", done, 0);
      end
      dmem_gnt = 1'b1;
      @(negedge clk);
      dmem_gnt = 1'b0;
      chk("req_rsp", dmem_req, 0);
      chk("no_done_rsp", done, 0);
      dmem_rvalid = 1'b1; dmem_rdata = rd;
      @(negedge clk);
      dmem_rvalid = 1'b0;
      chk("done", done, 1);
      chk("err_ok", err_code, 2'b00);
      chk("rdata_out", rdata_out, exp_rd);
      chk("stall_done", stall, 0);
      req_valid = 1'b0;
      @(negedge clk);
      chk("done_pulse", done, 0);
   endtask

   task automatic access_err(input logic ld, input logic st, input logic [2:0] f3,
                             input logic [31:0] a, input logic [1:0] exp_err);
      @(negedge clk);
      req_valid = 1'b1; is_load = ld; is_store = st; func3 = f3; addr = a; wdata = 32'h1234_5678;
      @(negedge clk);
      chk("err_done", done, 1);
      chk("err_code", err_code, exp_err);
      chk("err_noreq", dmem_req, 0);
      chk("err_rdata", rdata_out, 0);
      chk("err_stall", stall, 0);
      req_valid = 1'b0;
      @(negedge clk);
      chk("err_pulse", done, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0; req_valid = 1'b0; is_load = 1'b0; is_store = 1'b0; func3 = 3'b000;
      addr = '0; wdata = '0; dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = '0;
      repeat (2) @(negedge clk);
      chk("rst_done", done, 0);
      chk("rst_stall", stall, 0);
      chk("rst_err", err_code, 0);
      chk("rst_rdata", rdata_out, 0);
      chk("rst_req", dmem_req, 0);
      chk("rst_be", dmem_be, 0);
      rst_n = 1'b1;

      access_ok(1, 0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 4'b1111, 32'h0, 32'hDEADBEEF, 0);
      access_ok(1, 0, 3'b000, 32'h103, 32'h0, 32'h80112233, 4'b1000, 32'h0, 32'hFFFFFF80, 0);
      access_ok(1, 0, 3'b100, 32'h103, 32'h0, 32'h80112233, 4'b1000, 32'h0, 32'h00000080, 0);
      access_err(1, 0, 3'b010, 32'h101, 2'b01);
      access_err(0, 1, 3'b011, 32'h100, 2'b11);
      access_err(1, 1, 3'b010, 32'h100, 2'b11);
      access_err(0, 0, 3'b010, 32'h100, 2'b11);
      access_err(0, 1, 3'b100, 32'h100, 2'b11);
      access_ok(1, 0, 3'b001, 32'h102, 32'h0, 32'hBEEF1234, 4'b1100, 32'h0, 32'hFFFFBEEF, 0);
      access_ok(0, 1, 3'b001, 32'h102, 32'h0000ABCD, 32'h0, 4'b1100, 32'hABCDABCD, 32'h0, 3);
      access_ok(0, 1, 3'b000, 32'h101, 32'h0000005A, 32'h0, 4'b0010, 32'h5A5A5A5A, 32'h0, 0);
      access_ok(1, 0, 3'b101, 32'h102, 32'h0, 32'hBEEF1234, 4'b1100, 32'h0, 32'h0000BEEF, 0);

      // Granted but never answered: abort lands 64 cycles after entering REQ.
      @(negedge clk);
      req_valid = 1'b1; is_load = 1'b1; is_store = 1'b0; func3 = 3'b010; addr = 32'h200;
      for (int k = 1; k <= 65; k++) begin
         @(negedge clk);
         dmem_gnt = (k == 1);
         chk("tmo_done", {31'b0, done}, (k == 65) ? 32'd1 : 32'd0);
         if (k < 65) chk("tmo_stall", stall, 1);
      end
      dmem_gnt = 1'b0;
      chk("tmo_err", err_code, 2'b10);
      chk("tmo_rdata", rdata_out, 0);
      req_valid = 1'b0;

      access_ok(1, 0, 3'b010, 32'h108, 32'h0, 32'hCAFEF00D, 4'b1111, 32'h0, 32'hCAFEF00D, 0);

      @(negedge clk);
      req_valid = 1'b1; is_load = 1'b1; is_store = 1'b0; func3 = 3'b010; addr = 32'h300;
      @(negedge clk);
      dmem_gnt = 1'b1;
      @(negedge clk);
      dmem_gnt = 1'b0;
      rst_n = 1'b0; req_valid = 1'b0;
      #1;
      chk("arst_req", dmem_req, 0);
      chk("arst_addr", dmem_addr, 0);
      chk("arst_be", dmem_be, 0);
      chk("arst_rdata", rdata_out, 0);
      chk("arst_done", done, 0);
      chk("arst_stall", stall, 0);
      @(negedge clk);
      rst_n = 1'b1;

      access_ok(1, 0, 3'b010, 32'h104, 32'h0, 32'h12345678, 4'b1111, 32'h0, 32'h12345678, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
